// File: rtl/tdm_demux4_pkg.sv
// Shared definitions for the 4-slot TDM demultiplexer.
// Contents: frame-alignment state enum, slot geometry constants and a
// helper that turns a slot index into a one-hot channel write enable.
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;

    // One-hot channel select for a given slot index.
    function automatic logic [NUM_SLOTS-1:0] slot_onehot(input logic [SLOT_W-1:0] slot);
        slot_onehot = 4'b0001 << slot;
    endfunction

endpackage

// File: rtl/tdm_demux4_if.sv
// Bus interface of the TDM demultiplexer.
// Inputs (master -> slave): din, din_valid, frame_sync.
// Outputs (slave -> master): ch_data, ch_valid, frame_data, frame_valid,
// locked, sync_err. Channel k occupies bits [k*WIDTH +: WIDTH] of the
// packed data buses.
interface tdm_demux4_if
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]           din;
    logic                       din_valid;
    logic                       frame_sync;
    logic [NUM_SLOTS*WIDTH-1:0] ch_data;
    logic [NUM_SLOTS-1:0]       ch_valid;
    logic [NUM_SLOTS*WIDTH-1:0] frame_data;
    logic                       frame_valid;
    logic                       locked;
    logic                       sync_err;

    modport master (
        output din, din_valid, frame_sync,
        input  ch_data, ch_valid, frame_data, frame_valid, locked, sync_err
    );

    modport slave (
        input  din, din_valid, frame_sync,
        output ch_data, ch_valid, frame_data, frame_valid, locked, sync_err
    );
endinterface

// File: rtl/tdm_demux4_slot_ctrl.sv
// Frame alignment controller for the TDM demultiplexer.
// Tracks HUNT/LOCKED state and the current slot, and decides for each
// accepted word which channel (if any) it is written to.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   din_valid_i     a word is present this cycle
//   frame_sync_i    the present word is slot 0
//   wr_en_o         one-hot channel write enable for the present word (comb)
//   locked_o        registered: high while in LOCKED
//   sync_err_o      registered one-cycle alignment error strobe
module tdm_slot_ctrl
    import tdm_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 din_valid_i,
    input  logic                 frame_sync_i,
    output logic [NUM_SLOTS-1:0] wr_en_o,
    output logic                 locked_o,
    output logic                 sync_err_o
);

    state_e              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic                sync_err_q, sync_err_d;
    logic [NUM_SLOTS-1:0] wr_en_s;

    // State, slot counter and error strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            slot_q     <= {SLOT_W{1'b0}};
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            sync_err_q <= sync_err_d;
        end
    end

    // Next-state, slot advance, write enable and error decision.
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        sync_err_d = 1'b0;
        wr_en_s    = {NUM_SLOTS{1'b0}};
        if (din_valid_i) begin
            case (state_q)
                HUNT: begin
                    if (frame_sync_i) begin
                        wr_en_s = slot_onehot({SLOT_W{1'b0}});
                        slot_d  = SLOT_W'(1);
                        state_d = LOCKED;
                    end else begin
                        // Unaligned word: dropped while hunting.
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    if (frame_sync_i) begin
                        // A sync always restarts the frame at slot 0; if it
                        // arrives mid-frame the partial frame is abandoned.
                        sync_err_d = (slot_q != {SLOT_W{1'b0}});
                        wr_en_s    = slot_onehot({SLOT_W{1'b0}});
                        slot_d     = SLOT_W'(1);
                    end else if (slot_q == {SLOT_W{1'b0}}) begin
                        // Slot 0 without sync: alignment lost.
                        sync_err_d = 1'b1;
                        state_d    = HUNT;
                        slot_d     = {SLOT_W{1'b0}};
                    end else begin
                        wr_en_s = slot_onehot(slot_q);
                        slot_d  = slot_q + SLOT_W'(1);
                    end
                end
                default: begin
                    state_d = HUNT;
                    slot_d  = {SLOT_W{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    assign wr_en_o    = wr_en_s;
    assign locked_o   = (state_q == LOCKED);
    assign sync_err_o = sync_err_q;

endmodule

// File: rtl/tdm_demux4.sv
// Time-division 1:4 demultiplexer (receive end of a 4-slot TDM link).
// Steers each accepted word to its channel hold register, assembles
// complete frames in a shadow register and publishes them atomically.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          tdm_demux4_if slave: din/din_valid/frame_sync in;
//                ch_data/ch_valid/frame_data/frame_valid/locked/sync_err out
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    tdm_demux4_if.slave  bus
);

    logic [NUM_SLOTS-1:0]           wr_en_s;
    logic                           locked_s;
    logic                           sync_err_s;

    logic [NUM_SLOTS*WIDTH-1:0]     ch_data_q, ch_data_d;
    logic [NUM_SLOTS-1:0]           ch_valid_q, ch_valid_d;
    logic [(NUM_SLOTS-1)*WIDTH-1:0] shadow_q, shadow_d;
    logic [NUM_SLOTS*WIDTH-1:0]     frame_data_q, frame_data_d;
    logic                           frame_valid_q, frame_valid_d;

    tdm_slot_ctrl u_slot_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .din_valid_i  (bus.din_valid),
        .frame_sync_i (bus.frame_sync),
        .wr_en_o      (wr_en_s),
        .locked_o     (locked_s),
        .sync_err_o   (sync_err_s)
    );

    // Channel, shadow and frame register update from the write enables.
    always_comb begin
        ch_data_d     = ch_data_q;
        shadow_d      = shadow_q;
        frame_data_d  = frame_data_q;
        ch_valid_d    = wr_en_s;
        // Slot 3 can only be written after slots 0..2 of the same frame,
        // so its write enable doubles as the frame-complete strobe.
        frame_valid_d = wr_en_s[NUM_SLOTS-1];
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (wr_en_s[k]) begin
                ch_data_d[k*WIDTH +: WIDTH] = bus.din;
            end else begin
                ch_data_d[k*WIDTH +: WIDTH] = ch_data_q[k*WIDTH +: WIDTH];
            end
        end
        for (int k = 0; k < NUM_SLOTS-1; k++) begin
            if (wr_en_s[k]) begin
                shadow_d[k*WIDTH +: WIDTH] = bus.din;
            end else begin
                shadow_d[k*WIDTH +: WIDTH] = shadow_q[k*WIDTH +: WIDTH];
            end
        end
        if (wr_en_s[NUM_SLOTS-1]) begin
            frame_data_d = {bus.din, shadow_q};
        end else begin
            frame_data_d = frame_data_q;
        end
    end

    // Output and shadow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_data_q     <= {(NUM_SLOTS*WIDTH){1'b0}};
            ch_valid_q    <= {NUM_SLOTS{1'b0}};
            shadow_q      <= {((NUM_SLOTS-1)*WIDTH){1'b0}};
            frame_data_q  <= {(NUM_SLOTS*WIDTH){1'b0}};
            frame_valid_q <= 1'b0;
        end else begin
            ch_data_q     <= ch_data_d;
            ch_valid_q    <= ch_valid_d;
            shadow_q      <= shadow_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    assign bus.ch_data     = ch_data_q;
    assign bus.ch_valid    = ch_valid_q;
    assign bus.frame_data  = frame_data_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.locked      = locked_s;
    assign bus.sync_err    = sync_err_s;

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4: each driven cycle pushes the expected
// output snapshot from a frame-level reference model; a monitor on the
// falling edge pops and compares it with what the DUT presents.
module tb_tdm_demux4;

    logic clk;
    logic rst_n;

    tdm_demux4_if #(.WIDTH(8)) bus ();

    tdm_demux4 #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cv;
        logic [31:0] cd;
        logic        fv;
        logic [31:0] fd;
        logic        lk;
        logic        se;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: frame-level view of the link.
    bit          m_locked;
    logic [7:0]  m_ch [4];
    logic [7:0]  cur  [$];
    logic [31:0] m_fd;

    function void model_reset();
        m_locked = 1'b0;
        cur.delete();
        for (int i = 0; i < 4; i++) m_ch[i] = 8'h00;
        m_fd = 32'h0;
    endfunction

    function void model_edge(input logic v, input logic s, input logic [7:0] d);
        exp_t e;
        int   idx;
        e.cv = 4'b0000;
        e.fv = 1'b0;
        e.se = 1'b0;
        idx  = -1;
        if (v) begin
            if (!m_locked) begin
                if (s) begin
                    m_locked = 1'b1;
                    cur.delete();
                    cur.push_back(d);
                    idx = 0;
                end
            end else if (s) begin
                if (cur.size() != 0) e.se = 1'b1;
                cur.delete();
                cur.push_back(d);
                idx = 0;
            end else if (cur.size() == 0) begin
                e.se     = 1'b1;
                m_locked = 1'b0;
            end else begin
                cur.push_back(d);
                idx = cur.size() - 1;
            end
        end
        if (idx >= 0) begin
            m_ch[idx] = d;
            e.cv[idx] = 1'b1;
            if (cur.size() == 4) begin
                m_fd = {cur[3], cur[2], cur[1], cur[0]};
                e.fv = 1'b1;
                cur.delete();
            end
        end
        e.cd = {m_ch[3], m_ch[2], m_ch[1], m_ch[0]};
        e.fd = m_fd;
        e.lk = m_locked;
        exp_q.push_back(e);
    endfunction

    // Monitor: compare each expected snapshot one half-cycle after its edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (bus.ch_valid !== e.cv || bus.ch_data !== e.cd || bus.frame_valid !== e.fv ||
                bus.frame_data !== e.fd || bus.locked !== e.lk || bus.sync_err !== e.se) begin
                errors++;
                $display("FAIL out_cycle t=%0t: cv=%b/%b cd=%h/%h fv=%b/%b fd=%h/%h lk=%b/%b se=%b/%b (got/exp)",
                         $time, bus.ch_valid, e.cv, bus.ch_data, e.cd, bus.frame_valid, e.fv,
                         bus.frame_data, e.fd, bus.locked, e.lk, bus.sync_err, e.se);
            end
        end
    end

    task automatic check_zero(input string name);
        checks++;
        if (bus.ch_valid !== 4'b0 || bus.ch_data !== 32'h0 || bus.frame_valid !== 1'b0 ||
            bus.frame_data !== 32'h0 || bus.locked !== 1'b0 || bus.sync_err !== 1'b0) begin
            errors++;
            $display("FAIL %s: cv=%b cd=%h fv=%b fd=%h lk=%b se=%b, required all zero",
                     name, bus.ch_valid, bus.ch_data, bus.frame_valid, bus.frame_data,
                     bus.locked, bus.sync_err);
        end
    endtask

    task automatic step(input logic v, input logic s, input logic [7:0] d);
        bus.din_valid  = v;
        bus.frame_sync = s;
        bus.din        = d;
        @(posedge clk);
        model_edge(v, s, d);
        #1;
    endtask

    task automatic gap();
        step(1'b0, 1'b1, 8'($urandom_range(0, 255)));
    endtask

    initial begin
        int sent;
        logic v;
        logic s;
        rst_n          = 1'b0;
        bus.din        = 8'h00;
        bus.din_valid  = 1'b0;
        bus.frame_sync = 1'b0;
        model_reset();
        #3;
        check_zero("reset_state");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // HUNT drop.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'hAA);

        // Clean frame.
        step(1'b1, 1'b1, 8'h01);
        step(1'b1, 1'b0, 8'h02);
        step(1'b1, 1'b0, 8'h03);
        step(1'b1, 1'b0, 8'h04);

        // Gapped frame.
        gap();
        step(1'b1, 1'b1, 8'h01); gap(); gap();
        step(1'b1, 1'b0, 8'h02); gap();
        step(1'b1, 1'b0, 8'h03); gap(); gap(); gap();
        step(1'b1, 1'b0, 8'h04); gap();

        // Early sync, then completion of the restarted frame.
        step(1'b1, 1'b1, 8'h11);
        step(1'b1, 1'b0, 8'h22);
        step(1'b1, 1'b1, 8'h33);
        step(1'b1, 1'b0, 8'h44);
        step(1'b1, 1'b0, 8'h55);
        step(1'b1, 1'b0, 8'h66);

        // Missing sync after a full frame, then relock.
        step(1'b1, 1'b0, 8'h77);
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h88);
        step(1'b1, 1'b0, 8'h99);

        // Asynchronous reset mid-frame.
        step(1'b1, 1'b1, 8'h01);
        step(1'b1, 1'b0, 8'h02);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        check_zero("reset_hold");
        rst_n = 1'b1;
        step(1'b1, 1'b0, 8'h03);
        step(1'b1, 1'b0, 8'h04);
        step(1'b1, 1'b1, 8'hA0);
        step(1'b1, 1'b0, 8'hA1);
        step(1'b1, 1'b0, 8'hA2);
        step(1'b1, 1'b0, 8'hA3);

        // Randomized traffic, mostly aligned with occasional sync faults.
        sent = 0;
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            if (v) begin
                s = ((sent % 4) == 0) ^ ($urandom_range(0, 15) == 0);
                sent++;
            end else begin
                s = 1'($urandom_range(0, 1));
            end
            step(v, s, 8'($urandom_range(0, 255)));
        end

        step(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
